// File: rtl/wb_cfg_pkg.sv
// Shared constants and types for the Wishbone configuration loader.
//   OFF_*     : register offsets within the 256-byte Wishbone window
//   MAX_BITS  : default maximum bits shifted per column per data beat
//   CNT_W     : width of a per-column bit count (holds 0..MAX_BITS)
//   state_e   : loader FSM encoding
package wb_cfg_pkg;
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_COUNT  = 8'h01;
  localparam logic [7:0] OFF_DATA   = 8'h02;

  localparam int MAX_BITS = 8;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;
endpackage

// File: rtl/cfg_col_serializer.sv
// One fabric column's serializer. Captures the column's data byte and its
// effective bit count on the start pulse, then emits one bit per cycle,
// LSB first, while the shared index is below the captured count.
//   clk, rst   : clock, async active-high reset
//   load_i     : start-of-beat pulse; captures data_i / cnt_i
//   shift_i    : loader is in its shift phase
//   data_i     : byte for this column
//   cnt_i      : effective bit count (0 when the lane is not selected)
//   idx_i      : shared bit index driven by the loader
//   en_o/din_o : column shift enable / serial bit
module cfg_col_serializer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [7:0]    data_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] idx_i,
  output logic          en_o,
  output logic          din_o
);
  logic [7:0]    dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dat_sh;

  always_comb begin
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (load_i) begin
      dat_d = data_i;
      cnt_d = cnt_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  // Combinational from the loader state so an async reset kills en at once.
  assign dat_sh = dat_q >> idx_i;
  assign en_o   = shift_i & (idx_i < cnt_q);
  assign din_o  = en_o & dat_sh[0];
endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone slave that serializes configuration bytes into per-column fabric
// shift chains. One DATA write carries a byte per column; selected columns
// shift in parallel, each for its own programmed bit count.
//   wb_clk_i, wb_rst_i      : clock, async active-high reset
//   wbs_stb/cyc/we/sel/data/addr_i : Wishbone slave request
//   wbs_ack_o, wbs_data_o   : single-cycle ack, read data (0 unless acking)
//   cfg_en_o, cfg_din_o     : per-column shift enable / serial bit
//   busy_o                  : high while shifting
module wb_cfg_loader
  import wb_cfg_pkg::*;
#(
  parameter int          NCOL      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MAX_BITS  = wb_cfg_pkg::MAX_BITS
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_data_i,
  input  logic [31:0]     wbs_addr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_data_o,
  output logic [NCOL-1:0] cfg_en_o,
  output logic [NCOL-1:0] cfg_din_o,
  output logic            busy_o
);
  localparam int            CW   = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BITS);

  state_e                  state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           max_q, max_d;
  logic [15:0]             beat_q, beat_d;
  logic [NCOL-1:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0]              off_q, off_d;
  logic                    we_q, we_d;

  logic                    req, start;
  logic [NCOL-1:0][7:0]    lane_byte;
  logic [NCOL-1:0][CW-1:0] act_cnt;
  logic [CW-1:0]           act_max;
  logic [31:0]             rd_data;

  assign req   = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:8] == BASE_ADDR[31:8]);
  assign start = (state_q == ST_IDLE) & req & wbs_we_i & (wbs_addr_i[7:0] == OFF_DATA);

  // Effective count per lane: unselected lanes shift nothing this beat.
  always_comb begin
    act_max = '0;
    for (int c = 0; c < NCOL; c++) begin
      act_cnt[c] = wbs_sel_i[c] ? cnt_q[c] : '0;
      if (act_cnt[c] > act_max) act_max = act_cnt[c];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          off_d   = wbs_addr_i[7:0];
          we_d    = wbs_we_i;
          state_d = ST_ACK;
          if (wbs_we_i) begin
            case (wbs_addr_i[7:0])
              OFF_STATUS: if (wbs_sel_i[0]) beat_d = '0;
              OFF_COUNT: begin
                for (int c = 0; c < NCOL; c++)
                  if (wbs_sel_i[c])
                    cnt_d[c] = (lane_byte[c] > 8'(MAX_BITS)) ? MAXC : lane_byte[c][CW-1:0];
              end
              OFF_DATA: begin
                idx_d = '0;
                max_d = act_max;
                if (act_max != '0) state_d = ST_SHIFT;
              end
              default: ;
            endcase
          end
        end
      end
      ST_SHIFT: begin
        idx_d = idx_q + CW'(1);
        if (idx_q == max_q - CW'(1)) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (we_q && off_q == OFF_DATA) beat_d = beat_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      max_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= {NCOL{MAXC}};
      off_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  assign wbs_ack_o = (state_q == ST_ACK);
  assign busy_o    = (state_q == ST_SHIFT);

  always_comb begin
    rd_data = '0;
    if (wbs_ack_o && !we_q) begin
      case (off_q)
        OFF_STATUS: rd_data = {busy_o, 15'b0, beat_q};
        OFF_COUNT: begin
          for (int c = 0; c < NCOL; c++) rd_data[8*c +: 8] = 8'(cnt_q[c]);
        end
        default: rd_data = '0;
      endcase
    end
  end
  assign wbs_data_o = rd_data;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    assign lane_byte[c] = wbs_data_i[8*c +: 8];
    cfg_col_serializer #(.CW(CW)) u_col (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .load_i (start),
      .shift_i(busy_o),
      .data_i (lane_byte[c]),
      .cnt_i  (act_cnt[c]),
      .idx_i  (idx_q),
      .en_o   (cfg_en_o[c]),
      .din_o  (cfg_din_o[c])
    );
  end
endmodule

// File: doc/wb_cfg_loader.md
Name: wb_cfg_loader

Overview:
- Wishbone slave that accepts configuration bytes from the management core and serializes them into the fabric's per-column configuration shift chains.
- Each data write carries one byte per column, and the selected columns are shifted in parallel.
- A per-column bit-count register allows the final partial byte of a column bitstream.
- Sits between the Wishbone bus and the `fpga` top's column config chains, in place of ad-hoc direct chain drive.

Parameters:
- NCOL, 4, number of fabric columns; one byte lane each. NCOL must be ≤ 4.
- BASE_ADDR, 32'h3000_0000, Wishbone window base; matched on addr[31:8].
- MAX_BITS, 8, maximum bits shifted per column per data beat.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane select; lane c maps to column c.
- wbs_data_i  in  32  write data; byte c is for column c.
- wbs_addr_i  in  32  address.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_data_o  out  32  read data; valid only while ack is high, otherwise 0.
- cfg_en_o  out  NCOL  per-column shift enable.
- cfg_din_o  out  NCOL  per-column serial config bit.
- busy_o  out  1  high while in SHIFT.

Behaviour:
- Request: stb & cyc & (addr[31:8]==BASE_ADDR[31:8]). Requests are sampled only in IDLE. Non-matching addresses get no ack.
- Register offsets (addr[7:0]):
  - 0x00 STATUS. Read returns {busy, 15'b0, beat_cnt[15:0]}. A write with sel[0] clears beat_cnt.
  - 0x01 COUNT. Byte c = bit count for column c. Read returns the counts zero-extended per byte. A write updates only selected lanes; values > MAX_BITS clamp to MAX_BITS.
  - 0x02 DATA. Write starts a shift beat. Read returns 0.
  - Other offsets: acked, write ignored, read returns 0.
- Reset values:
  - ack=0, data_o=0, cfg_en=0, cfg_din=0, busy=0.
  - All counts = MAX_BITS; beat_cnt=0; FSM=IDLE.
- FSM states: IDLE, SHIFT, ACK.
  - IDLE: on a request to DATA with we=1, latch data bytes and sel. The active set is lanes with sel[c]=1 and count[c]>0. Set idx=0 and move to SHIFT; if the active set is empty, go straight to ACK. Any other request goes to ACK.
  - SHIFT: each cycle, for every active column with idx<count[c], drive cfg_en[c]=1 and cfg_din[c]=byte[c][idx] (LSB first); other columns get en=0, din=0. idx increments each cycle. Exit to ACK after the cycle where idx = max active count − 1.
  - ACK: ack=1 for exactly one cycle, with read data presented. A DATA write increments beat_cnt (wraps 0xFFFF→0). Next state is IDLE.
- Latency:
  - Request sampled at edge k.
  - Non-DATA and empty-DATA accesses: ack in cycle k+1.
  - DATA with max active count N: cfg_en high in cycles k+1..k+N, ack in cycle k+N+1.
- A master holding stb after ack gets a new transaction in the following IDLE cycle. This is legal Wishbone behaviour; masters must drop stb on ack.
- Inputs are ignored during SHIFT/ACK; stb is not re-sampled.
- Mid-operation: cyc dropping during SHIFT does not abort the beat; the beat completes and acks.
- Reset asserted mid-beat: cfg_en drops immediately (async) and the beat is discarded.
- Counts are read at beat start and are stable during SHIFT.

Decomposition:
- Package `wb_cfg_pkg`: register offsets (OFF_STATUS, OFF_COUNT, OFF_DATA), FSM state encoding, MAX_BITS, and the count width $clog2(MAX_BITS+1).
- Sub-module `cfg_col_serializer` (one per column): holds the byte and count, and produces en/din from a shared idx and start pulse.
- The top module holds the Wishbone decode, FSM, idx counter and beat_cnt.

Test Plan:
- Reset then read STATUS → ack after 1 cycle, data 32'h0000_0000. Read COUNT → 32'h0808_0808.
- Write COUNT 32'hFF03_0000 with sel=4'b1100 → read COUNT returns 32'h0803_0808 (lane 3 clamped to 8, lanes 0/1 unchanged).
- After reset, write DATA 32'h00A5_3C81, sel=4'b0111:
  - cfg_en=3'b111 for 8 cycles; col0 din sequence 1,0,0,0,0,0,0,1; col1 0,0,1,1,1,1,0,0; col2 1,0,1,0,0,1,0,1.
  - cfg_en[3]=0 throughout; ack in cycle 9; STATUS beat_cnt=1.
- Set COUNT lanes = {0,2,5,3}, then write DATA 32'hFFFF_FFFF with sel=4'b1111:
  - col0 en for 3 cycles, col1 for 5, col2 for 2, col3 never.
  - ack in cycle 6.
- Set all counts 0, then write DATA → ack next cycle, no cfg_en pulses, beat_cnt increments.
- Assert wb_rst_i in SHIFT cycle 3 → cfg_en=0 in the same cycle; after release no ack, counts read back 8, beat_cnt=0. An access to 0x3000_0100 receives no ack.
